calc_key_entry: RTL and testbench
=================================

Name: calc_key_entry

Overview:
- Sequential keypad front end that builds the operands consumed by the BCD add/subtract datapath.
- Accepts one-cycle key events and assembles operand A (`num`), operand B (`sub`) and the operation code (`sign`) as 3-digit BCD.
- Pulses `calc_go` when the operands are final, and tracks entry phase for the display path.
- Sits between the keypad scanner and the arithmetic block; it is the writer for the arithmetic block's `{sign, num, sub}` interface.

Parameters:
- MAX_DIGITS, 3, maximum digits accepted per operand (legal 1..3); further digit keys are ignored.
- KEY_ADD, 4'hA, key code for "+".
- KEY_SUB, 4'hB, key code for "-".
- KEY_EQ, 4'hC, key code for "=".
- KEY_CLR, 4'hD, key code for clear.
- KEY_BSP, 4'hE, key code for backspace. Code 4'hF and any unmapped code are ignored.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0..9 digits, else per parameters.
- num  out  12  operand A, BCD `{n1,n2,n3}`.
- sub  out  12  operand B, BCD `{n1,n2,n3}`.
- sign  out  4  4'd10 = add, 4'd11 = subtract.
- calc_go  out  1  one-cycle pulse; operands final.
- phase  out  2  0 = ENTER_A, 1 = OP_SEL, 2 = ENTER_B, 3 = DONE.
- entry  out  12  operand currently being edited (A in phases 0/1, B in phases 2/3), for display.

Behaviour:
- Reset (async, rst_n low): num=0, sub=0, sign=4'd10, calc_go=0, phase=0, digit counts cleared. All outputs are registered.
- Events are processed only when key_valid=1. Every effect is visible on the cycle after the strobe edge (1-cycle latency).
- Digit entry into operand X (count cX):
  - If cX<MAX_DIGITS: X <= {X[7:0], d}.
  - cX increments, except when X==0 and d==0. Leading zeros are not counted.
  - If cX==MAX_DIGITS: the key is ignored.
- Backspace on X:
  - If cX>0: X <= {4'd0, X[11:4]}, cX decrements.
  - If cX==0: no-op.
- ENTER_A:
  - Digit → edit A.
  - KEY_ADD / KEY_SUB → sign=10 / 11, go OP_SEL.
  - KEY_BSP → edit A.
  - KEY_EQ → ignored.
- OP_SEL:
  - KEY_ADD / KEY_SUB → replace sign and stay.
  - Digit → sub <= {8'd0, d}, count per digit rule, go ENTER_B.
  - KEY_BSP → back to ENTER_A; A and sign unchanged.
  - KEY_EQ → sub=0, calc_go pulse, go DONE.
- ENTER_B:
  - Digit / KEY_BSP → edit B. Backspace with cB==0 returns to OP_SEL with sub=0.
  - KEY_EQ → calc_go pulse, go DONE.
  - KEY_ADD / KEY_SUB → ignored (no chaining).
- DONE:
  - num/sub/sign hold stable.
  - Digit → num <= {8'd0, d}, sub=0, sign=10, counts reset then digit rule applied, go ENTER_A.
  - KEY_ADD / KEY_SUB / KEY_EQ / KEY_BSP → ignored.
- KEY_CLR in any state: same values as reset, next cycle.
- calc_go is high for exactly one cycle per accepted "=". Consecutive strobes produce independent pulses. An "=" arriving while calc_go is high is handled by the normal state rules.
- num/sub always hold valid BCD (every nibble ≤9). No binary arithmetic is performed here.
- rst_n asserted mid-entry or during the calc_go cycle: everything clears immediately and calc_go drops asynchronously.

Test Plan:
1. Reset, keys 1,2,3,KEY_SUB,4,5,KEY_EQ:
   - num=12'h123, sub=12'h045, sign=11.
   - calc_go high exactly one cycle after "=", phase=3.
2. Keys 0,0,7,KEY_ADD,9,9,9,9,KEY_EQ:
   - num=12'h007 (leading zeros not counted), sub=12'h999 (4th 9 ignored), sign=10, one calc_go.
3. Keys 5,6,KEY_BSP,KEY_BSP,KEY_BSP,8:
   - num=12'h008, phase=0.
   - Third backspace is a no-op.
4. Keys 3,KEY_SUB,KEY_ADD,KEY_EQ:
   - sign=10, sub=0, calc_go pulse.
   - Then digit 4 → num=12'h004, sub=0, phase=0.
5. Keys 9,KEY_SUB,2,KEY_CLR:
   - Next cycle all outputs at reset values.
   - Also drive rst_n low mid-entry: outputs clear immediately, without a clock edge.
6. Keys 4,KEY_ADD,KEY_BSP:
   - phase=0, num=12'h004.
   - Then KEY_EQ in ENTER_A → no calc_go, state unchanged.

Source files
------------

// File: rtl/calc_key_entry.sv
// Keypad front end for the BCD add/subtract datapath.
// Collects one-cycle key events into two 3-digit BCD operands and an
// operation code, and pulses calc_go when the operands are final.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   key_valid, key_code : one-cycle key strobe and its code
//   num, sub, sign      : operand A, operand B, op code (10 add, 11 subtract)
//   calc_go             : one-cycle pulse, operands final
//   phase               : 0 ENTER_A, 1 OP_SEL, 2 ENTER_B, 3 DONE
//   entry               : operand currently being edited, for display
module calc_key_entry #(
  parameter int unsigned MAX_DIGITS = 3,
  parameter logic [3:0]  KEY_ADD    = 4'hA,
  parameter logic [3:0]  KEY_SUB    = 4'hB,
  parameter logic [3:0]  KEY_EQ     = 4'hC,
  parameter logic [3:0]  KEY_CLR    = 4'hD,
  parameter logic [3:0]  KEY_BSP    = 4'hE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [11:0] num,
  output logic [11:0] sub,
  output logic [3:0]  sign,
  output logic        calc_go,
  output logic [1:0]  phase,
  output logic [11:0] entry
);

  localparam int unsigned CW = 2;
  localparam logic [3:0] SIGN_ADD = 4'd10;
  localparam logic [3:0] SIGN_SUB = 4'd11;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    OP_SEL  = 2'd1,
    ENTER_B = 2'd2,
    DONE    = 2'd3
  } phase_e;

  phase_e        phase_q, phase_d;
  logic [11:0]   num_q, num_d;
  logic [11:0]   sub_q, sub_d;
  logic [3:0]    sign_q, sign_d;
  logic          calc_go_q, calc_go_d;
  logic [11:0]   entry_q, entry_d;
  logic [CW-1:0] ca_q, ca_d;
  logic [CW-1:0] cb_q, cb_d;

  logic is_digit;
  logic is_op;
  logic a_full;
  logic b_full;
  logic a_cnt;
  logic b_cnt;
  logic d_cnt;

  // Digit classification and counting: leading zeros do not consume a slot.
  always_comb begin
    is_digit = (key_code <= 4'd9);
    is_op    = (key_code == KEY_ADD) || (key_code == KEY_SUB);
    a_full   = (ca_q >= CW'(MAX_DIGITS));
    b_full   = (cb_q >= CW'(MAX_DIGITS));
    a_cnt    = !((num_q == 12'd0) && (key_code == 4'd0));
    b_cnt    = !((sub_q == 12'd0) && (key_code == 4'd0));
    d_cnt    = (key_code != 4'd0);
  end

  // Next-state and output values.
  always_comb begin
    phase_d   = phase_q;
    num_d     = num_q;
    sub_d     = sub_q;
    sign_d    = sign_q;
    ca_d      = ca_q;
    cb_d      = cb_q;
    calc_go_d = 1'b0;

    if (key_valid) begin
      if (key_code == KEY_CLR) begin
        phase_d = ENTER_A;
        num_d   = 12'd0;
        sub_d   = 12'd0;
        sign_d  = SIGN_ADD;
        ca_d    = '0;
        cb_d    = '0;
      end else begin
        unique case (phase_q)
          ENTER_A: begin
            if (is_digit) begin
              if (!a_full) begin
                num_d = {num_q[7:0], key_code};
                if (a_cnt) ca_d = ca_q + CW'(1);
              end
            end else if (is_op) begin
              sign_d  = (key_code == KEY_SUB) ? SIGN_SUB : SIGN_ADD;
              phase_d = OP_SEL;
            end else if (key_code == KEY_BSP) begin
              if (ca_q != '0) begin
                num_d = {4'd0, num_q[11:4]};
                ca_d  = ca_q - CW'(1);
              end
            end
          end
          OP_SEL: begin
            if (is_op) begin
              sign_d = (key_code == KEY_SUB) ? SIGN_SUB : SIGN_ADD;
            end else if (is_digit) begin
              sub_d   = {8'd0, key_code};
              cb_d    = CW'(d_cnt);
              phase_d = ENTER_B;
            end else if (key_code == KEY_BSP) begin
              phase_d = ENTER_A;
            end else if (key_code == KEY_EQ) begin
              sub_d     = 12'd0;
              cb_d      = '0;
              calc_go_d = 1'b1;
              phase_d   = DONE;
            end
          end
          ENTER_B: begin
            if (is_digit) begin
              if (!b_full) begin
                sub_d = {sub_q[7:0], key_code};
                if (b_cnt) cb_d = cb_q + CW'(1);
              end
            end else if (key_code == KEY_BSP) begin
              if (cb_q != '0) begin
                sub_d = {4'd0, sub_q[11:4]};
                cb_d  = cb_q - CW'(1);
              end else begin
                // Nothing left to erase: fall back to operator selection.
                sub_d   = 12'd0;
                phase_d = OP_SEL;
              end
            end else if (key_code == KEY_EQ) begin
              calc_go_d = 1'b1;
              phase_d   = DONE;
            end
          end
          DONE: begin
            // A digit starts a fresh calculation; everything else is ignored.
            if (is_digit) begin
              num_d   = {8'd0, key_code};
              ca_d    = CW'(d_cnt);
              sub_d   = 12'd0;
              cb_d    = '0;
              sign_d  = SIGN_ADD;
              phase_d = ENTER_A;
            end
          end
          default: phase_d = ENTER_A;
        endcase
      end
    end

    entry_d = ((phase_d == ENTER_B) || (phase_d == DONE)) ? sub_d : num_d;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= ENTER_A;
      num_q     <= 12'd0;
      sub_q     <= 12'd0;
      sign_q    <= SIGN_ADD;
      calc_go_q <= 1'b0;
      entry_q   <= 12'd0;
      ca_q      <= '0;
      cb_q      <= '0;
    end else begin
      phase_q   <= phase_d;
      num_q     <= num_d;
      sub_q     <= sub_d;
      sign_q    <= sign_d;
      calc_go_q <= calc_go_d;
      entry_q   <= entry_d;
      ca_q      <= ca_d;
      cb_q      <= cb_d;
    end
  end

  assign num     = num_q;
  assign sub     = sub_q;
  assign sign    = sign_q;
  assign calc_go = calc_go_q;
  assign phase   = phase_q;
  assign entry   = entry_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Self-checking bench for calc_key_entry: directed scenarios plus random
// key streams compared against a decimal-value reference model.
module tb_calc_key_entry;

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_EQ  = 4'hC;
  localparam logic [3:0] K_CLR = 4'hD;
  localparam logic [3:0] K_BSP = 4'hE;
  localparam int         MAXD  = 3;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] num;
  logic [11:0] sub;
  logic [3:0]  sign;
  logic        calc_go;
  logic [1:0]  phase;
  logic [11:0] entry;

  int n_tests;
  int n_fail;

  // Reference model: operands held as decimal integers plus digit counts.
  int m_a, m_ca, m_b, m_cb, m_sign, m_phase, m_go;

  calc_key_entry dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_valid(key_valid),
    .key_code (key_code),
    .num      (num),
    .sub      (sub),
    .sign     (sign),
    .calc_go  (calc_go),
    .phase    (phase),
    .entry    (entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [42:0] exp_vec();
    int e;
    e = (m_phase >= 2) ? m_b : m_a;
    return {to_bcd(m_a), to_bcd(m_b), 4'(m_sign), 1'(m_go), 2'(m_phase), to_bcd(e)};
  endfunction

  function automatic logic [42:0] act_vec();
    return {num, sub, sign, calc_go, phase, entry};
  endfunction

  task automatic model_reset();
    m_a = 0; m_ca = 0; m_b = 0; m_cb = 0; m_sign = 10; m_phase = 0; m_go = 0;
  endtask

  task automatic append(inout int v, inout int c, input int d);
    if (c < MAXD) begin
      if (!(v == 0 && d == 0)) c++;
      v = v * 10 + d;
    end
  endtask

  task automatic model_key(input logic [3:0] k);
    int d;
    d = int'(k);
    m_go = 0;
    if (k == K_CLR) begin
      model_reset();
    end else begin
      case (m_phase)
        0: begin
          if (d <= 9) append(m_a, m_ca, d);
          else if (k == K_ADD || k == K_SUB) begin
            m_sign = (k == K_SUB) ? 11 : 10; m_phase = 1;
          end else if (k == K_BSP && m_ca > 0) begin
            m_a = m_a / 10; m_ca--;
          end
        end
        1: begin
          if (k == K_ADD || k == K_SUB) m_sign = (k == K_SUB) ? 11 : 10;
          else if (d <= 9) begin
            m_b = d; m_cb = (d != 0) ? 1 : 0; m_phase = 2;
          end else if (k == K_BSP) m_phase = 0;
          else if (k == K_EQ) begin
            m_b = 0; m_cb = 0; m_go = 1; m_phase = 3;
          end
        end
        2: begin
          if (d <= 9) append(m_b, m_cb, d);
          else if (k == K_BSP) begin
            if (m_cb > 0) begin
              m_b = m_b / 10; m_cb--;
            end else begin
              m_b = 0; m_phase = 1;
            end
          end else if (k == K_EQ) begin
            m_go = 1; m_phase = 3;
          end
        end
        default: begin
          if (d <= 9) begin
            m_a = d; m_ca = (d != 0) ? 1 : 0; m_b = 0; m_cb = 0;
            m_sign = 10; m_phase = 0;
          end
        end
      endcase
    end
  endtask

  // Called at #1 after an edge; strobes one key and returns #1 after the next edge.
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'hF;
    model_key(k);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    m_go = 0;
  endtask

  task automatic press_seq(input logic [3:0] ks[], input int n);
    for (int i = 0; i < n; i++) press(ks[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (act_vec() !== {12'h000, 12'h000, 4'd10, 1'b0, 2'd0, 12'h000}) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", act_vec(), {12'h000, 12'h000, 4'd10, 1'b0, 2'd0, 12'h000});
    end
  endtask

  task automatic test_sub_basic();
    logic [3:0] ks[] = '{4'd1, 4'd2, 4'd3, K_SUB, 4'd4, 4'd5, K_EQ};
    press_seq(ks, 7);
    n_tests++;
    if (act_vec() !== {12'h123, 12'h045, 4'd11, 1'b1, 2'd3, 12'h045}) begin
      n_fail++;
      $display("FAIL sub_basic_eq: got %h want %h", act_vec(), {12'h123, 12'h045, 4'd11, 1'b1, 2'd3, 12'h045});
    end
    idle();
    n_tests++;
    if (calc_go !== 1'b0 || phase !== 2'd3) begin
      n_fail++;
      $display("FAIL sub_basic_go_once: calc_go=%b phase=%0d want 0/3", calc_go, phase);
    end
  endtask

  task automatic test_leading_zero_and_overflow();
    logic [3:0] ks[] = '{K_CLR, 4'd0, 4'd0, 4'd7, K_ADD, 4'd9, 4'd9, 4'd9, 4'd9, K_EQ};
    int gos;
    gos = 0;
    for (int i = 0; i < 10; i++) begin
      press(ks[i]);
      if (calc_go === 1'b1) gos++;
    end
    n_tests++;
    if (act_vec() !== {12'h007, 12'h999, 4'd10, 1'b1, 2'd3, 12'h999}) begin
      n_fail++;
      $display("FAIL lz_overflow: got %h want %h", act_vec(), {12'h007, 12'h999, 4'd10, 1'b1, 2'd3, 12'h999});
    end
    n_tests++;
    if (gos != 1) begin
      n_fail++;
      $display("FAIL lz_overflow_gocount: got %0d want 1", gos);
    end
    idle();
  endtask

  task automatic test_backspace();
    logic [3:0] ks[] = '{K_CLR, 4'd5, 4'd6, K_BSP, K_BSP, K_BSP, 4'd8};
    press_seq(ks, 7);
    n_tests++;
    if (act_vec() !== {12'h008, 12'h000, 4'd10, 1'b0, 2'd0, 12'h008}) begin
      n_fail++;
      $display("FAIL backspace: got %h want %h", act_vec(), {12'h008, 12'h000, 4'd10, 1'b0, 2'd0, 12'h008});
    end
  endtask

  task automatic test_op_replace_and_restart();
    logic [3:0] ks[] = '{K_CLR, 4'd3, K_SUB, K_ADD, K_EQ};
    press_seq(ks, 5);
    n_tests++;
    if (act_vec() !== {12'h003, 12'h000, 4'd10, 1'b1, 2'd3, 12'h000}) begin
      n_fail++;
      $display("FAIL op_replace: got %h want %h", act_vec(), {12'h003, 12'h000, 4'd10, 1'b1, 2'd3, 12'h000});
    end
    press(4'd4);
    n_tests++;
    if (act_vec() !== {12'h004, 12'h000, 4'd10, 1'b0, 2'd0, 12'h004}) begin
      n_fail++;
      $display("FAIL done_restart: got %h want %h", act_vec(), {12'h004, 12'h000, 4'd10, 1'b0, 2'd0, 12'h004});
    end
  endtask

  task automatic test_clear_and_async_reset();
    logic [3:0] ks[] = '{4'd9, K_SUB, 4'd2, K_CLR};
    press_seq(ks, 4);
    n_tests++;
    if (act_vec() !== {12'h000, 12'h000, 4'd10, 1'b0, 2'd0, 12'h000}) begin
      n_fail++;
      $display("FAIL clr_key: got %h want %h", act_vec(), {12'h000, 12'h000, 4'd10, 1'b0, 2'd0, 12'h000});
    end
    // Mid-entry asynchronous reset, sampled between clock edges.
    press(4'd9); press(K_SUB); press(4'd2);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_rst_mid: got %h want %h", act_vec(), exp_vec());
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // Asynchronous reset during the calc_go cycle.
    press(4'd1); press(K_ADD); press(4'd1); press(K_EQ);
    n_tests++;
    if (calc_go !== 1'b1) begin
      n_fail++;
      $display("FAIL async_rst_go_pre: calc_go=%b want 1", calc_go);
    end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_rst_go: got %h want %h", act_vec(), exp_vec());
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_opsel_bsp_and_eq_ignored();
    logic [3:0] ks[] = '{K_CLR, 4'd4, K_ADD, K_BSP};
    press_seq(ks, 4);
    n_tests++;
    if (act_vec() !== {12'h004, 12'h000, 4'd10, 1'b0, 2'd0, 12'h004}) begin
      n_fail++;
      $display("FAIL opsel_bsp: got %h want %h", act_vec(), {12'h004, 12'h000, 4'd10, 1'b0, 2'd0, 12'h004});
    end
    press(K_EQ);
    n_tests++;
    if (act_vec() !== {12'h004, 12'h000, 4'd10, 1'b0, 2'd0, 12'h004}) begin
      n_fail++;
      $display("FAIL eq_in_enter_a: got %h want %h", act_vec(), {12'h004, 12'h000, 4'd10, 1'b0, 2'd0, 12'h004});
    end
  endtask

  task automatic test_back_to_back();
    // B backspaced past empty returns to OP_SEL; then two "=" in a row.
    logic [3:0] ks[] = '{K_CLR, 4'd6, K_SUB, 4'd2, K_BSP, K_BSP};
    press_seq(ks, 6);
    n_tests++;
    if (act_vec() !== exp_vec() || phase !== 2'd1) begin
      n_fail++;
      $display("FAIL b_bsp_empty: got %h want %h", act_vec(), exp_vec());
    end
    press(4'd3);
    press(K_EQ);
    n_tests++;
    if (act_vec() !== exp_vec() || calc_go !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_eq1: got %h want %h", act_vec(), exp_vec());
    end
    press(K_EQ);
    n_tests++;
    if (act_vec() !== exp_vec() || calc_go !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_eq2: got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [3:0] k;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle();
      end else begin
        if ($urandom_range(0, 1) == 0) k = 4'($urandom_range(0, 9));
        else k = 4'($urandom_range(10, 15));
        if (k == K_CLR && $urandom_range(0, 3) != 0) k = K_EQ;
        press(k);
      end
      n_tests++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    model_reset();
    test_reset();
    test_sub_basic();
    test_leading_zero_and_overflow();
    test_backspace();
    test_op_replace_and_restart();
    test_clear_and_async_reset();
    test_opsel_bsp_and_eq_ignored();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
